rf_wb_arb: RTL and testbench
============================

RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 Parameter XLEN, default 32, register data width.
REQ-002 Parameter FIFO_DEPTH, default 2, entries in the requester-B buffer, power of two, >=2.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive cycles B may lose to A before B is forced.
REQ-004 clk  in  1  single clock; all state on posedge.
REQ-005 reset  in  1  asynchronous, active-low; asserting it forces reset state immediately.
REQ-006 a_valid / a_ready / a_addr / a_data  in/out/in/in  1/1/5/XLEN  pipeline writeback requester.
REQ-007 b_valid / b_ready / b_addr / b_data  in/out/in/in  1/1/5/XLEN  long-latency unit requester.
REQ-008 sb_set / sb_set_addr  in/in  1/5  issue stage marks rd busy for a long-latency op.
REQ-009 rs1_addr / rs2_addr  in/in  5/5  decode-stage source registers.
REQ-010 rs1_busy / rs2_busy  out/out  1/1  source hazard flags, combinational.
REQ-011 reg_write_enable / reg_write_addr / reg_write_data  out/out/out  1/5/XLEN  registered drive of the register-file write port.

Function
REQ-012 b_ready SHALL equal FIFO-not-full; push on b_valid && b_ready.
REQ-013 No FIFO bypass: a B entry accepted in cycle t is grant-eligible from cycle t+1.
REQ-014 force_b = FIFO-not-empty && starve_cnt == STARVE_LIMIT; a_ready SHALL equal !force_b.
REQ-015 Grant per cycle: B (pop FIFO head) if FIFO-not-empty && (!a_valid || force_b); else A if a_valid; else none.
REQ-016 starve_cnt SHALL increment, saturating at STARVE_LIMIT, when FIFO is non-empty and A is granted; clear to 0 when B is granted or FIFO is empty.
REQ-017 On grant in cycle t, in cycle t+1 reg_write_addr/data SHALL carry the granted addr/data and reg_write_enable SHALL be 1 iff addr != 0.
REQ-018 With no grant, reg_write_enable SHALL be 0 next cycle; addr/data hold.
REQ-019 Latency: A accepted at t writes the RF at end of t+1; B accepted at t writes no earlier than end of t+2.
REQ-020 Scoreboard: 32 busy bits; bit 0 constant 0; sb_set with sb_set_addr != 0 sets the bit at posedge.
REQ-021 A B grant SHALL clear busy[b head addr] at the same posedge.
REQ-022 Set and clear of the same address in one cycle: set wins.
REQ-023 rsN_busy = busy[rsN_addr] || (reg_write_enable && reg_write_addr == rsN_addr && rsN_addr != 0).
REQ-024 A writes SHALL NOT touch the scoreboard.
REQ-025 FIFO ordering strictly first-in-first-out; push and pop in the same cycle allowed when non-empty.

Reset
REQ-026 Reset SHALL empty the FIFO, clear all busy bits, zero starve_cnt, drive reg_write_enable=0, reg_write_addr=0, reg_write_data=0.
REQ-027 Reset mid-operation discards buffered B entries; no write issues after reset assertion.
REQ-028 Out of reset: b_ready=1, a_ready=1, rs1_busy=rs2_busy=0.

Structure
REQ-029 Package rf_arb_pkg SHALL hold REG_ADDR_W=5, NUM_REGS=32, XLEN default and the grant-select encoding (GNT_NONE, GNT_A, GNT_B).
REQ-030 The B buffer SHALL be a sub-module wb_fifo (parameterised width/depth, full/empty/push/pop).
REQ-031 Arbiter, starvation counter, scoreboard and output register reside in rf_wb_arb.

Verification
REQ-032 A only: a_valid=1, a_addr=5, a_data=0x1234 at t -> t+1 reg_write_enable=1, addr=5, data=0x1234; a_ready stays 1.
REQ-033 x0: a_addr=0, data=0xFFFF_FFFF -> a_ready=1, reg_write_enable stays 0.
REQ-034 Starvation: a_valid held 1, one B entry (addr 7) -> A wins 4 cycles, 5th cycle a_ready=0 and B granted, addr 7 written next cycle, starve_cnt=0.
REQ-035 Scoreboard: sb_set addr 9; rs1_addr=9 -> rs1_busy=1 until the B write to 9 is on the port, 0 from the cycle after that.
REQ-036 FIFO full: a_valid=1 continuously, 2 B pushes -> b_ready=0; third B value held until a pop, order preserved.
REQ-037 Reset asserted with 2 B entries and busy bits set -> outputs zero immediately, busy clear, b_ready=1, no stale write after release.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: register-file writeback arbiter constants and the grant-select encoding
package rf_arb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam int XLEN_DEFAULT = 32;
  typedef enum logic [1:0] {GNT_NONE, GNT_A, GNT_B} gnt_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: FIFO without bypass; ports are clk, active-low async reset, push_i/pop_i/wdata_i, rdata_o head, full_o/empty_o
module wb_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(do_push);
      rd_q <= rd_q + (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/rf_wb_arb.sv
// rf_wb_arb: writeback arbiter (A pipeline / B buffered long-latency) with starvation guard, busy scoreboard, registered RF write port and rs1/rs2 hazard flags
module rf_wb_arb
  import rf_arb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [XLEN-1:0]       a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [XLEN-1:0]       b_data,
  input  logic                  sb_set,
  input  logic [REG_ADDR_W-1:0] sb_set_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  reg_write_enable,
  output logic [REG_ADDR_W-1:0] reg_write_addr,
  output logic [XLEN-1:0]       reg_write_data
);
  localparam int EW = REG_ADDR_W + XLEN;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [EW-1:0] head;
  logic full, empty, force_b;
  logic [REG_ADDR_W-1:0] head_addr, win_addr;
  logic [XLEN-1:0] head_data, win_data;
  gnt_e gnt;
  logic [SW-1:0] starve_q, starve_d;
  logic [NUM_REGS-1:0] busy_q, busy_d, clr_mask, set_mask;
  logic we_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [XLEN-1:0] data_q;
  wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(b_valid),
    .pop_i(gnt == GNT_B),
    .wdata_i({b_addr, b_data}),
    .rdata_o(head),
    .full_o(full),
    .empty_o(empty)
  );
  assign head_addr = head[EW-1 -: REG_ADDR_W];
  assign head_data = head[XLEN-1:0];
  assign b_ready = !full;
  assign force_b = !empty && starve_q == SW'(STARVE_LIMIT);
  assign a_ready = !force_b;
  assign gnt = (!empty && (!a_valid || force_b)) ? GNT_B : a_valid ? GNT_A : GNT_NONE;
  assign win_addr = gnt == GNT_B ? head_addr : a_addr;
  assign win_data = gnt == GNT_B ? head_data : a_data;
  assign starve_d = (empty || gnt == GNT_B) ? '0 :
                    (gnt == GNT_A && starve_q != SW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
  assign clr_mask = gnt == GNT_B ? NUM_REGS'(1) << head_addr : '0;
  assign set_mask = sb_set ? NUM_REGS'(1) << sb_set_addr : '0;
  assign busy_d = ((busy_q & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
  assign rs1_busy = busy_q[rs1_addr] || (we_q && addr_q == rs1_addr && rs1_addr != '0);
  assign rs2_busy = busy_q[rs2_addr] || (we_q && addr_q == rs2_addr && rs2_addr != '0);
  assign reg_write_enable = we_q;
  assign reg_write_addr = addr_q;
  assign reg_write_data = data_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
      busy_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q <= busy_d;
      we_q <= gnt != GNT_NONE && win_addr != '0;
      if (gnt != GNT_NONE) begin
        addr_q <= win_addr;
        data_q <= win_data;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arb.sv
// tb_rf_wb_arb: directed and randomized stimulus checked against a queue-based reference model
module tb_rf_wb_arb;
  localparam int XLEN = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  typedef struct {
    logic [4:0] addr;
    logic [31:0] data;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a_valid = 0, b_valid = 0, sb_set = 0;
  logic a_ready, b_ready, rs1_busy, rs2_busy, reg_write_enable;
  logic [4:0] a_addr = 0, b_addr = 0, sb_set_addr = 0, rs1_addr = 0, rs2_addr = 0, reg_write_addr;
  logic [XLEN-1:0] a_data = 0, b_data = 0, reg_write_data;
  int checks = 0;
  int failures = 0;
  ent_t q[$];
  logic [31:0] busy = '0;
  int starve = 0;
  logic m_we = 0;
  logic [4:0] m_addr = 0;
  logic [31:0] m_data = 0;
  always #5 clk = ~clk;
  rf_wb_arb #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .reg_write_enable(reg_write_enable), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                      input bit ss, input logic [4:0] sa, input logic [4:0] r1, input logic [4:0] r2,
                      output bit acc);
    bit frc, have;
    int n;
    ent_t g;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    sb_set = ss; sb_set_addr = sa; rs1_addr = r1; rs2_addr = r2;
    #1;
    n = q.size();
    frc = n > 0 && starve == LIMIT;
    chk("a_ready", a_ready, !frc);
    chk("b_ready", b_ready, n < DEPTH);
    chk("rs1_busy", rs1_busy, busy[r1] || (m_we && m_addr == r1 && r1 != 0));
    chk("rs2_busy", rs2_busy, busy[r2] || (m_we && m_addr == r2 && r2 != 0));
    have = 0;
    g = '{5'd0, 32'd0};
    if (n > 0 && (!av || frc)) begin
      g = q.pop_front();
      busy[g.addr] = 1'b0;
      have = 1;
      starve = 0;
    end else if (av) begin
      g = '{aa, ad};
      have = 1;
      starve = n == 0 ? 0 : (starve < LIMIT ? starve + 1 : LIMIT);
    end else begin
      starve = 0;
    end
    acc = bv && n < DEPTH;
    if (acc) q.push_back('{ba, bd});
    if (ss && sa != 0) busy[sa] = 1'b1;
    if (have) begin
      m_we = g.addr != 0;
      m_addr = g.addr;
      m_data = g.data;
    end else m_we = 0;
    @(posedge clk);
    #1;
    chk("we", reg_write_enable, m_we);
    chk("waddr", reg_write_addr, m_addr);
    chk("wdata", reg_write_data, m_data);
  endtask
  task automatic do_reset(input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    rs1_addr = r1; rs2_addr = r2;
    #2 reset = 1'b0;
    #1;
    chk("rst_we", reg_write_enable, 0);
    chk("rst_waddr", reg_write_addr, 0);
    chk("rst_wdata", reg_write_data, 0);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_rs1_busy", rs1_busy, 0);
    chk("rst_rs2_busy", rs2_busy, 0);
    q.delete();
    busy = '0; starve = 0; m_we = 0; m_addr = 0; m_data = 0;
    @(posedge clk);
    #1 chk("rst_hold_we", reg_write_enable, 0);
    @(negedge clk);
    a_valid = 0; b_valid = 0; sb_set = 0;
    reset = 1'b1;
  endtask
  initial begin
    bit acc;
    int k, budget;
    repeat (2) @(posedge clk);
    #1;
    chk("init_we", reg_write_enable, 0);
    chk("init_waddr", reg_write_addr, 0);
    chk("init_wdata", reg_write_data, 0);
    chk("init_b_ready", b_ready, 1);
    chk("init_a_ready", a_ready, 1);
    @(negedge clk) reset = 1'b1;
    step(1, 5, 32'h1234, 0, 0, 0, 0, 0, 5, 0, acc);
    step(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 5, acc);
    step(1, 1, 32'h11, 1, 7, 32'hB7, 1, 7, 7, 1, acc);
    for (int i = 0; i < 7; i++) step(1, 5'(2 + i), 32'h100 + i, 0, 0, 0, 0, 0, 7, 0, acc);
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0, acc);
    step(0, 0, 0, 1, 9, 32'h9999, 0, 0, 9, 9, acc);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 9, 9, acc);
    k = 0;
    budget = 0;
    while (k < 3 && budget < 40) begin
      step(1, 5'(20 + budget % 4), 32'hA000 + budget, 1, 5'(10 + k), 32'hC000 + k, 0, 0, 5'(10 + k), 0, acc);
      if (acc) k++;
      budget++;
    end
    chk("fifo_full_accept", k, 3);
    for (int i = 0; i < 12; i++) step(1, 3, 32'hD00 + i, 0, 0, 0, 0, 0, 10, 11, acc);
    step(0, 0, 0, 0, 0, 0, 1, 13, 13, 14, acc);
    step(0, 0, 0, 0, 0, 0, 1, 14, 13, 14, acc);
    step(1, 4, 32'h44, 1, 13, 32'hE13, 0, 0, 13, 14, acc);
    step(1, 4, 32'h45, 1, 14, 32'hE14, 0, 0, 13, 14, acc);
    do_reset(13, 14);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 13, 14, acc);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      else step($urandom_range(0, 99) < 65, 5'($urandom_range(0, 31)), $urandom,
                $urandom_range(0, 99) < 45, 5'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 99) < 25, 5'($urandom_range(0, 15)),
                5'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), acc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
